// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor.
// Holds the ID comparator branch-type encodings, the 2-bit counter states
// and the saturating counter next-state function.
package bp_pkg;

  // Branch-type encodings, shared with the ID-stage comparator.
  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_BEQZ  = 2'b01;
  localparam logic [1:0] BR_BNEQZ = 2'b10;

  // 2-bit direction counter: strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating step: taken moves toward ST, not-taken moves toward SNT.
  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
    ctr_e nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) nxt = ctr_e'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/ID <-> branch predictor signal bundle.
// master: the pipeline side (drives fetch PC and ID resolution, receives
//         prediction, redirect and statistics).
// slave:  the predictor.
interface branch_predictor_if;
  // Fetch-side lookup
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  // ID-side resolution
  logic        id_valid;
  logic        id_stall;
  logic [31:0] id_pc;
  logic [1:0]  id_branch_type;
  logic        id_branch_taken;
  logic [31:0] id_target;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  // Correction
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  // Statistics
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output if_pc, id_valid, id_stall, id_pc, id_branch_type, id_branch_taken,
           id_target, id_pred_taken, id_pred_target,
    input  pred_taken, pred_target, redirect_valid, redirect_pc, flush_if_id,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_pc, id_branch_type, id_branch_taken,
           id_target, id_pred_taken, id_pred_target,
    output pred_taken, pred_target, redirect_valid, redirect_pc, flush_if_id,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating direction counter, next-state only.
// Ports:
//   ctr     - current counter state
//   taken   - resolved branch direction
//   ctr_nxt - counter state after training with 'taken'
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr_next(ctr, taken);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters predicting BEQZ/BNEQZ at IF.
// Lookup is combinational from the registered tables; the resolved outcome
// from ID raises redirect/flush on a mispredict and trains the tables at the
// next rising edge. Also keeps saturating branch/mispredict counters.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - fetch lookup, ID resolution, redirect and statistics (slave side)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [29:0]      tgt_q   [ENTRIES];
  ctr_e             ctr_q   [ENTRIES];

  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  // Fetch-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             pred_taken;

  assign if_idx     = bus.if_pc[IDX_W+1:2];
  assign if_tag     = bus.if_pc[31:IDX_W+2];
  assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken = if_hit && (ctr_q[if_idx] inside {WT, ST});

  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_taken ? {tgt_q[if_idx], 2'b00} : bus.if_pc + 32'd4;

  // ID-side resolution
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             id_hit;
  logic             evaluate;
  logic             is_branch;
  logic             mispredict;
  logic             is_alias;
  logic             redirect;
  logic [31:0]      fall_through;
  ctr_e             ctr_upd;

  assign id_idx       = bus.id_pc[IDX_W+1:2];
  assign id_tag       = bus.id_pc[31:IDX_W+2];
  assign id_hit       = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign fall_through = bus.id_pc + 32'd4;

  always_comb begin
    evaluate   = bus.id_valid & ~bus.id_stall;
    is_branch  = (bus.id_branch_type == BR_BEQZ) || (bus.id_branch_type == BR_BNEQZ);
    mispredict = (bus.id_pred_taken != bus.id_branch_taken) ||
                 (bus.id_branch_taken && (bus.id_pred_target != bus.id_target));
    // A non-branch that fetch predicted taken hit a stale or aliased entry.
    is_alias   = ~is_branch & bus.id_pred_taken;
    redirect   = ~rst & evaluate & ((is_branch & mispredict) | is_alias);
  end

  assign bus.redirect_valid = redirect;
  assign bus.flush_if_id    = redirect;
  assign bus.redirect_pc    = !redirect ? 32'd0 :
                              (is_branch && bus.id_branch_taken) ? bus.id_target :
                              fall_through;

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;

  bp_sat_ctr2 u_ctr (
    .ctr     (ctr_q[id_idx]),
    .taken   (bus.id_branch_taken),
    .ctr_nxt (ctr_upd)
  );

  // Table and statistics update; reset wins over any pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (evaluate) begin
      if (is_branch) begin
        if (id_hit) begin
          ctr_q[id_idx] <= ctr_upd;
          if (bus.id_branch_taken) tgt_q[id_idx] <= bus.id_target[31:2];
        end else if (bus.id_branch_taken) begin
          // Allocation overwrites whatever tag held this index.
          valid_q[id_idx] <= 1'b1;
          tag_q[id_idx]   <= id_tag;
          tgt_q[id_idx]   <= bus.id_target[31:2];
          ctr_q[id_idx]   <= WT;
        end
        if (stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
        if (mispredict && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + 32'd1;
      end else if (bus.id_pred_taken) begin
        valid_q[id_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed plan steps followed by
// randomized traffic, all checked against a behavioural BTB model.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bus ();

  branch_predictor #(.ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: 16 entries, tag = pc >> 6, counter as an integer 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_br;
  longint      m_mp;

  // DUT values observed before the edge in the most recent cycle.
  logic        obs_pt;
  logic [31:0] obs_ptg;
  logic        obs_rv;
  logic [31:0] obs_rpc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output logic t,
                                    output logic [31:0] tg);
    int unsigned i = (pc >> 2) % 16;
    bit hit = m_valid[i] && (m_tag[i] == (pc >> 6));
    t  = hit && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic drive(input bit v, input bit st, input logic [31:0] pc, input logic [1:0] ty,
                       input bit tk, input logic [31:0] tgt, input bit pt,
                       input logic [31:0] ptg);
    bus.id_valid        = v;
    bus.id_stall        = st;
    bus.id_pc           = pc;
    bus.id_branch_type  = ty;
    bus.id_branch_taken = tk;
    bus.id_target       = tgt;
    bus.id_pred_taken   = pt;
    bus.id_pred_target  = ptg;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // One clock: check combinational outputs, take the edge, update the model,
  // check statistics.
  task automatic cycle();
    logic et;
    logic [31:0] etg;
    bit ev, br, misp, rv, tk;
    logic [31:0] rpc;
    int unsigned i, tg;
    #1;
    m_predict(bus.if_pc, et, etg);
    obs_pt  = bus.pred_taken;
    obs_ptg = bus.pred_target;
    obs_rv  = bus.redirect_valid;
    obs_rpc = bus.redirect_pc;
    check("pred_taken", {31'b0, bus.pred_taken}, {31'b0, et});
    check("pred_target", bus.pred_target, etg);
    ev   = bus.id_valid && !bus.id_stall;
    br   = (bus.id_branch_type == 2'b01) || (bus.id_branch_type == 2'b10);
    tk   = bus.id_branch_taken;
    misp = (bus.id_pred_taken != tk) || (tk && (bus.id_pred_target != bus.id_target));
    rv   = 1'b0;
    rpc  = 32'd0;
    if (!rst && ev && br && misp) begin
      rv  = 1'b1;
      rpc = tk ? bus.id_target : bus.id_pc + 32'd4;
    end else if (!rst && ev && !br && bus.id_pred_taken) begin
      rv  = 1'b1;
      rpc = bus.id_pc + 32'd4;
    end
    check("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, rv});
    check("flush_if_id", {31'b0, bus.flush_if_id}, {31'b0, rv});
    if (rv || rst) check("redirect_pc", bus.redirect_pc, rpc);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (ev) begin
      i  = (bus.id_pc >> 2) % 16;
      tg = bus.id_pc >> 6;
      if (br) begin
        if (m_valid[i] && m_tag[i] == tg) begin
          if (tk) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = bus.id_target & ~32'h3;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (tk) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = tg;
          m_tgt[i]   = bus.id_target & ~32'h3;
          m_ctr[i]   = 2;
        end
        m_br++;
        if (misp) m_mp++;
      end else if (bus.id_pred_taken) begin
        m_valid[i] = 1'b0;
      end
    end
    #1;
    check("stat_branches", bus.stat_branches, m_br[31:0]);
    check("stat_mispredicts", bus.stat_mispredicts, m_mp[31:0]);
  endtask

  logic [31:0] pcs [5];

  initial begin
    logic        mpt;
    logic [31:0] mptg;
    logic [31:0] pc;
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h440; pcs[3] = 32'h84; pcs[4] = 32'h1000;

    // Reset
    rst = 1'b1;
    bus.if_pc = 32'h40;
    idle();
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 1'b0;
    cycle();
    check("reset_pred_taken", {31'b0, obs_pt}, 32'd0);
    check("reset_pred_target", obs_ptg, 32'h44);
    check("reset_stat_br", bus.stat_branches, 32'd0);

    // First taken BEQZ at 0x40: mispredict, allocate
    drive(1'b1, 1'b0, 32'h40, BR_BEQZ, 1'b1, 32'h80, 1'b0, 32'h44);
    cycle();
    check("first_redirect_valid", {31'b0, obs_rv}, 32'd1);
    check("first_redirect_pc", obs_rpc, 32'h80);
    idle();
    cycle();
    check("alloc_pred_taken", {31'b0, obs_pt}, 32'd1);
    check("alloc_pred_target", obs_ptg, 32'h80);
    check("alloc_stat_mp", bus.stat_mispredicts, 32'd1);

    // Two correct taken resolutions, then a not-taken
    repeat (2) begin
      drive(1'b1, 1'b0, 32'h40, BR_BEQZ, 1'b1, 32'h80, 1'b1, 32'h80);
      cycle();
      check("correct_no_redirect", {31'b0, obs_rv}, 32'd0);
    end
    drive(1'b1, 1'b0, 32'h40, BR_BNEQZ, 1'b0, 32'h80, 1'b1, 32'h80);
    cycle();
    check("nt_redirect_pc", obs_rpc, 32'h44);
    idle();
    cycle();
    check("nt_still_taken", {31'b0, obs_pt}, 32'd1);

    // Alias: non-branch predicted taken
    drive(1'b1, 1'b0, 32'h40, BR_NONE, 1'b0, 32'h0, 1'b1, 32'h80);
    cycle();
    check("alias_redirect_pc", obs_rpc, 32'h44);
    idle();
    cycle();
    check("alias_invalidated", {31'b0, obs_pt}, 32'd0);
    check("alias_no_stat", bus.stat_branches, 32'd4);

    // Mispredicting branch stalled for 3 cycles, then released
    bus.if_pc = 32'h104;
    repeat (3) begin
      drive(1'b1, 1'b1, 32'h104, BR_BEQZ, 1'b1, 32'h200, 1'b0, 32'h108);
      cycle();
      check("stall_no_redirect", {31'b0, obs_rv}, 32'd0);
      check("stall_stat_mp", bus.stat_mispredicts, 32'd2);
    end
    drive(1'b1, 1'b0, 32'h104, BR_BEQZ, 1'b1, 32'h200, 1'b0, 32'h108);
    cycle();
    check("unstall_redirect_pc", obs_rpc, 32'h200);
    check("unstall_stat_br", bus.stat_branches, 32'd5);
    check("unstall_stat_mp", bus.stat_mispredicts, 32'd3);

    // Reset pulse with a pending update in the same cycle
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h300, BR_BEQZ, 1'b1, 32'h400, 1'b0, 32'h304);
    cycle();
    check("rst_redirect_valid", {31'b0, obs_rv}, 32'd0);
    rst = 1'b0;
    idle();
    cycle();
    check("post_rst_pred", {31'b0, obs_pt}, 32'd0);
    check("post_rst_stat_br", bus.stat_branches, 32'd0);
    bus.if_pc = 32'h300;
    cycle();
    check("post_rst_pending_dropped", {31'b0, obs_pt}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.if_pc = pcs[$urandom_range(0, 4)];
      pc = pcs[$urandom_range(0, 4)];
      m_predict(pc, mpt, mptg);
      if ($urandom_range(0, 9) < 2) begin
        mpt  = $urandom_range(0, 1);
        mptg = ($urandom_range(0, 1) == 1) ? 32'h200 : pc + 32'd4;
      end
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, pc,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 32'h200 : ($urandom() & ~32'h3), mpt, mptg);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
